// File: rtl/video_pixel_feeder_if.sv
// Bundle between the VRAM display reader, the pixel feeder and the HDMI timing generator.
// Push: a word transfers on a posedge where in_valid && in_ready; pix_en pops one pixel per cycle.
interface video_pixel_feeder_if #(
    parameter int DEPTH    = 64,
    parameter int H_ACTIVE = 720,
    parameter int V_ACTIVE = 480
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(H_ACTIVE * V_ACTIVE) + 1;

    logic [15:0]   in_pixel;
    logic          in_sof;
    logic          in_valid;
    logic          in_ready;
    logic          pix_en;
    logic [35:0]   out_data;
    logic          underflow;
    logic          sync_err;
    logic          frame_done;
    // Debug view of the FSM and occupancy for checkers.
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_count;
    logic [PW-1:0] dbg_pix_cnt;

    modport master (
        output in_pixel, in_sof, in_valid, pix_en,
        input  in_ready, out_data, underflow, sync_err, frame_done,
        input  dbg_state, dbg_count, dbg_pix_cnt
    );

    modport slave (
        input  in_pixel, in_sof, in_valid, pix_en,
        output in_ready, out_data, underflow, sync_err, frame_done,
        output dbg_state, dbg_count, dbg_pix_cnt
    );
endinterface

// File: rtl/video_pixel_feeder.sv
// FWFT FIFO feeding RGB555 pixels, expanded to RGB 12:12:12, into the HDMI timing generator.
// Tracks frame position per pix_en and flags underflow and SOF desync.
module video_pixel_feeder #(
    parameter int DEPTH    = 64,
    parameter int H_ACTIVE = 720,
    parameter int V_ACTIVE = 480
) (
    input logic                 clk,
    input logic                 rst,
    video_pixel_feeder_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int PW    = $clog2(TOTAL) + 1;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        STREAM   = 2'd1
    } state_e;

    state_e        state_q, state_d;
    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] pix_cnt_q;
    logic          underflow_q, sync_err_q, frame_done_q;

    logic          in_ready, wr_en, pop_req;
    logic          empty, full, pop, desync, wrap;
    logic [16:0]   head;
    logic [35:0]   out_data;

    function automatic logic [11:0] expand5(input logic [4:0] c);
        return {c, c, c[4:3]};
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // A popped entry must carry sof exactly when the counter is at frame start.
    assign pop    = pop_req && !empty;
    assign desync = pop && (head[15] ? (pix_cnt_q != '0) : (pix_cnt_q == '0));
    assign wrap   = pop_req && !desync && (pix_cnt_q == PW'(TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (wr_en)  state_d = STREAM;
            STREAM:   if (desync) state_d = WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // No push while full, even when a pop frees a slot in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        pop_req  = 1'b0;
        if (!rst) begin
            case (state_q)
                WAIT_SOF: begin
                    in_ready = 1'b1;
                    wr_en    = bus.in_valid && bus.in_sof;
                end
                STREAM: begin
                    in_ready = !full;
                    wr_en    = bus.in_valid && !full;
                    pop_req  = bus.pix_en;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_sof, bus.in_pixel[14:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pix_cnt_q    <= '0;
            underflow_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (desync) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                pix_cnt_q <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(wr_en) - CW'(pop);
                // The counter advances even on underflow to stay locked to the generator.
                if (pop_req) pix_cnt_q <= wrap ? '0 : pix_cnt_q + 1'b1;
            end
            underflow_q  <= underflow_q | (pop_req && empty);
            sync_err_q   <= sync_err_q | desync;
            frame_done_q <= wrap;
        end
    end

    always_comb begin
        out_data = 36'h0;
        if (!empty) begin
            out_data = {expand5(head[4:0]), expand5(head[9:5]), expand5(head[14:10])};
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_data    = out_data;
    assign bus.underflow   = underflow_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_count   = count_q;
    assign bus.dbg_pix_cnt = pix_cnt_q;
endmodule

// File: tb/tb_video_pixel_feeder.sv
// Directed bench for video_pixel_feeder with a 4x2 frame and an 8-entry FIFO.
module tb_video_pixel_feeder;
    localparam int DEPTH = 8;
    localparam int H_ACT = 4;
    localparam int V_ACT = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    video_pixel_feeder_if #(.DEPTH(DEPTH), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) bus ();

    video_pixel_feeder #(.DEPTH(DEPTH), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] px [8];

    function automatic logic [35:0] exp36(input logic [15:0] p);
        logic [4:0] r, g, b;
        r = p[4:0];
        g = p[9:5];
        b = p[14:10];
        return {r, r, r[4:3], g, g, g[4:3], b, b, b[4:3]};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 16'h0;
        bus.pix_en   = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic [15:0] p, input logic s);
        int n;
        n = 0;
        bus.in_pixel = p;
        bus.in_sof   = s;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", {35'h0, bus.in_ready}, 36'h1);
        step();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [35:0] exp);
        bus.pix_en = 1'b1;
        #1;
        chk(tag, bus.out_data, exp);
        step();
        bus.pix_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        px[0] = 16'h001F; px[1] = 16'h03E0; px[2] = 16'h7C00; px[3] = 16'h1234;
        px[4] = 16'h2A55; px[5] = 16'h5AA5; px[6] = 16'h7FFF; px[7] = 16'h0842;

        // Reset state
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 16'h0;
        bus.pix_en   = 1'b0;
        #2;
        chk("rst_in_ready", {35'h0, bus.in_ready}, 36'h0);
        chk("rst_out_data", bus.out_data, 36'h0);
        chk("rst_flags", {33'h0, bus.underflow, bus.sync_err, bus.frame_done}, 36'h0);
        chk("rst_state", {34'h0, bus.dbg_state}, 36'h0);
        do_reset();
        chk("post_rst_ready", {35'h0, bus.in_ready}, 36'h1);

        // Colour expansion
        push(16'h7FFF, 1'b1);
        chk("col_state", {34'h0, bus.dbg_state}, 36'h1);
        pop("col_white", 36'hFFFFFFFFF);
        push(16'h0001, 1'b0);
        pop("col_r1", 36'h084000000);
        push(16'h8000, 1'b0);
        pop("col_mask", 36'h0);
        chk("col_flags", {34'h0, bus.underflow, bus.sync_err}, 36'h0);

        // Frame streaming
        do_reset();
        for (int i = 0; i < 8; i++) push(px[i], i == 0);
        chk("frm_count", {32'h0, bus.dbg_count}, 36'd8);
        chk("frm_full_ready", {35'h0, bus.in_ready}, 36'h0);
        for (int i = 0; i < 8; i++) begin
            pop($sformatf("frm_pix%0d", i), exp36(px[i]));
            if (i == 6) chk("frm_done_early", {35'h0, bus.frame_done}, 36'h0);
        end
        chk("frm_done", {35'h0, bus.frame_done}, 36'h1);
        step();
        chk("frm_done_pulse", {35'h0, bus.frame_done}, 36'h0);
        chk("frm_flags", {34'h0, bus.underflow, bus.sync_err}, 36'h0);
        chk("frm_pixcnt", {32'h0, bus.dbg_pix_cnt}, 36'h0);

        // Pre-SOF discard and backpressure
        do_reset();
        for (int i = 0; i < 3; i++) push(px[i + 1], 1'b0);
        chk("disc_count", {32'h0, bus.dbg_count}, 36'd0);
        chk("disc_state", {34'h0, bus.dbg_state}, 36'h0);
        for (int i = 0; i < 8; i++) push(px[i], i == 0);
        bus.in_pixel = 16'h0F0F;
        bus.in_sof   = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("bp_ready_low", {35'h0, bus.in_ready}, 36'h0);
        step();
        chk("bp_count_hold", {32'h0, bus.dbg_count}, 36'd8);
        bus.pix_en = 1'b1;
        #1;
        chk("bp_ready_pop", {35'h0, bus.in_ready}, 36'h0);
        step();
        bus.pix_en = 1'b0;
        #1;
        chk("bp_count_pop", {32'h0, bus.dbg_count}, 36'd7);
        chk("bp_ready_high", {35'h0, bus.in_ready}, 36'h1);
        chk("bp_head", bus.out_data, exp36(px[1]));
        step();
        bus.in_valid = 1'b0;
        chk("bp_count_9th", {32'h0, bus.dbg_count}, 36'd8);

        // Underflow
        do_reset();
        push(px[3], 1'b1);
        push(px[4], 1'b0);
        pop("uf_pix1", exp36(px[3]));
        pop("uf_pix2", exp36(px[4]));
        chk("uf_flag_clear", {35'h0, bus.underflow}, 36'h0);
        pop("uf_black1", 36'h0);
        chk("uf_flag_set", {35'h0, bus.underflow}, 36'h1);
        pop("uf_black2", 36'h0);
        chk("uf_pixcnt", {32'h0, bus.dbg_pix_cnt}, 36'd4);
        chk("uf_sync", {35'h0, bus.sync_err}, 36'h0);

        // Desync
        do_reset();
        for (int i = 0; i < 8; i++) push(px[i], (i == 0) || (i == 2));
        pop("ds_pix0", exp36(px[0]));
        pop("ds_pix1", exp36(px[1]));
        chk("ds_sync_clear", {35'h0, bus.sync_err}, 36'h0);
        pop("ds_pix2", exp36(px[2]));
        chk("ds_sync_set", {35'h0, bus.sync_err}, 36'h1);
        chk("ds_count", {32'h0, bus.dbg_count}, 36'd0);
        chk("ds_state", {34'h0, bus.dbg_state}, 36'h0);
        chk("ds_pixcnt", {32'h0, bus.dbg_pix_cnt}, 36'd0);
        chk("ds_out_black", bus.out_data, 36'h0);
        push(px[3], 1'b0);
        chk("ds_discard", {32'h0, bus.dbg_count}, 36'd0);
        push(px[4], 1'b1);
        chk("ds_resync_count", {32'h0, bus.dbg_count}, 36'd1);
        chk("ds_resync_state", {34'h0, bus.dbg_state}, 36'h1);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 8; i++) push(px[i], i == 0);
        for (int i = 0; i < 5; i++) pop($sformatf("mr_pix%0d", i), exp36(px[i]));
        chk("mr_count_pre", {32'h0, bus.dbg_count}, 36'd3);
        rst = 1'b1;
        #1;
        chk("mr_in_ready", {35'h0, bus.in_ready}, 36'h0);
        chk("mr_out_data", bus.out_data, 36'h0);
        chk("mr_flags", {33'h0, bus.underflow, bus.sync_err, bus.frame_done}, 36'h0);
        step();
        rst = 1'b0;
        #1;
        chk("mr_state", {34'h0, bus.dbg_state}, 36'h0);
        chk("mr_count", {32'h0, bus.dbg_count}, 36'd0);
        chk("mr_ready_after", {35'h0, bus.in_ready}, 36'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
